// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller takes the master modport; the datapath (or a bench) takes the slave.
interface multicycle_control_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           PCSource, state, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           PCSource, state, illegal_op
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch/decode/
// execute/memory/write-back and drives every datapath mux and enable.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 (waits on mem_ready)
// DECODE   | read registers, precompute branch target
// MEMADR   | compute lw/sw effective address
// MEMREAD  | data memory read (waits on mem_ready)
// MEMWB    | write loaded word to rt
// MEMWRITE | data memory write (waits on mem_ready)
// EXECUTE  | R-type ALU operation
// ALUWB    | write ALU result to rd
// BRANCH   | beq compare and conditional PC load
// JUMP     | PC load from jump target
// ADDIEX   | addi ALU operation
// ADDIWB   | write addi result to rt
module multicycle_control_fsm (
  input logic                        clk,
  input logic                        reset,
  multicycle_control_fsm_if.master   ctl_if
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDIEX   = 4'd10,
    ADDIWB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_e     state_q, state_d;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       memto_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    memto_reg     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    illegal       = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ctl_if.mem_ready;
        pc_write  = ctl_if.mem_ready;
        state_d   = ctl_if.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (ctl_if.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // IR holds the opcode here; a corrupted one falls back to FETCH
        if (ctl_if.opcode == OP_LW)      state_d = MEMREAD;
        else if (ctl_if.opcode == OP_SW) state_d = MEMWRITE;
        else                             state_d = FETCH;
      end
      MEMREAD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = ctl_if.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        reg_write = 1'b1;
        memto_reg = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = ctl_if.mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Outputs are squashed combinationally so nothing leaks during the reset cycle
  assign ctl_if.PCWrite     = pc_write      & ~reset;
  assign ctl_if.PCWriteCond = pc_write_cond & ~reset;
  assign ctl_if.IorD        = iord          & ~reset;
  assign ctl_if.MemRead     = mem_read      & ~reset;
  assign ctl_if.MemWrite    = mem_write     & ~reset;
  assign ctl_if.IRWrite     = ir_write      & ~reset;
  assign ctl_if.MemtoReg    = memto_reg     & ~reset;
  assign ctl_if.RegDst      = reg_dst       & ~reset;
  assign ctl_if.RegWrite    = reg_write     & ~reset;
  assign ctl_if.ALUSrcA     = alu_src_a     & ~reset;
  assign ctl_if.illegal_op  = illegal       & ~reset;
  assign ctl_if.ALUSrcB     = reset ? 2'b00 : alu_src_b;
  assign ctl_if.ALUOp       = reset ? 2'b00 : alu_op;
  assign ctl_if.PCSource    = reset ? 2'b00 : pc_source;
  assign ctl_if.state       = reset ? 4'd0  : state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-instruction expected state
// traces and control words are built from the instruction/stall description.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .clk    (clk),
    .reset  (reset),
    .ctl_if (bus.master)
  );

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       memto_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit supported(input logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
           op == OP_J || op == OP_ADDI;
  endfunction

  function automatic ctl_t exp_out(input int st, input bit mr, input logic [5:0] op);
    ctl_t c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      1:  begin c.alu_src_b = 2'b11; c.illegal = !supported(op); end
      2, 10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.reg_write = 1; c.memto_reg = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
      11: begin c.reg_write = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t dut_out();
    ctl_t c;
    c.pc_write      = bus.PCWrite;
    c.pc_write_cond = bus.PCWriteCond;
    c.iord          = bus.IorD;
    c.mem_read      = bus.MemRead;
    c.mem_write     = bus.MemWrite;
    c.ir_write      = bus.IRWrite;
    c.memto_reg     = bus.MemtoReg;
    c.reg_dst       = bus.RegDst;
    c.reg_write     = bus.RegWrite;
    c.alu_src_a     = bus.ALUSrcA;
    c.alu_src_b     = bus.ALUSrcB;
    c.alu_op        = bus.ALUOp;
    c.pc_source     = bus.PCSource;
    c.illegal       = bus.illegal_op;
    return c;
  endfunction

  // Runs one instruction (or its first `limit` cycles). Called just after a
  // rising edge with the DUT in FETCH; returns just after the last edge.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input int limit, input string tag,
                           output int ir_pulses, output int mw_pulses);
    int st_q[$];
    bit mr_q[$];
    int n;
    ctl_t got, exp;
    ir_pulses = 0;
    mw_pulses = 0;
    for (int i = 0; i < fw; i++) begin st_q.push_back(0); mr_q.push_back(0); end
    st_q.push_back(0); mr_q.push_back(1);
    st_q.push_back(1); mr_q.push_back(1'($urandom_range(0, 1)));
    case (op)
      OP_R:    begin st_q.push_back(6);  mr_q.push_back(1'($urandom_range(0, 1)));
                     st_q.push_back(7);  mr_q.push_back(1'($urandom_range(0, 1))); end
      OP_ADDI: begin st_q.push_back(10); mr_q.push_back(1'($urandom_range(0, 1)));
                     st_q.push_back(11); mr_q.push_back(1'($urandom_range(0, 1))); end
      OP_LW: begin
        st_q.push_back(2); mr_q.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin st_q.push_back(3); mr_q.push_back(0); end
        st_q.push_back(3); mr_q.push_back(1);
        st_q.push_back(4); mr_q.push_back(1'($urandom_range(0, 1)));
      end
      OP_SW: begin
        st_q.push_back(2); mr_q.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) begin st_q.push_back(5); mr_q.push_back(0); end
        st_q.push_back(5); mr_q.push_back(1);
      end
      OP_BEQ:  begin st_q.push_back(8); mr_q.push_back(1'($urandom_range(0, 1))); end
      OP_J:    begin st_q.push_back(9); mr_q.push_back(1'($urandom_range(0, 1))); end
      default: ;
    endcase
    n = (limit > 0 && limit < st_q.size()) ? limit : st_q.size();
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = mr_q[i];
      bus.opcode    = (st_q[i] == 0) ? 6'($urandom) : op;
      @(negedge clk);
      n_cmp++;
      if (bus.state !== 4'(st_q[i])) begin
        n_bad++;
        $display("FAIL %s state cycle %0d: got %0d expected %0d", tag, i, bus.state, st_q[i]);
      end
      got = dut_out();
      exp = exp_out(st_q[i], mr_q[i], op);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL %s outputs cycle %0d (state %0d): got %h expected %h",
                 tag, i, st_q[i], got, exp);
      end
      if (got.ir_write === 1'b1) ir_pulses++;
      if (got.mem_write === 1'b1) mw_pulses++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_fetch_idle(input string tag);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.state !== 4'd0 || dut_out() !== exp_out(0, 0, bus.opcode)) begin
      n_bad++;
      $display("FAIL %s: got state %0d outputs %h expected state 0 outputs %h",
               tag, bus.state, dut_out(), exp_out(0, 0, bus.opcode));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int a, b;
    run_instr(OP_LW, 0, 4, 4, "pre_reset", a, b);
    reset = 1'b1; bus.opcode = OP_R; bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_out() !== ctl_t'(0) || bus.state !== 4'd0) begin
        n_bad++;
        $display("FAIL reset_hold cycle %0d: got outputs %h state %0d expected 0 / 0",
                 i, dut_out(), bus.state);
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.state !== 4'd0 || bus.MemRead !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: got state %0d MemRead %b expected 0 / 1",
               bus.state, bus.MemRead);
    end
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rtype();
    int a, b;
    run_instr(OP_R, 0, 0, 0, "rtype", a, b);
    run_instr(OP_ADDI, 0, 0, 0, "addi", a, b);
  endtask

  task automatic test_lw_stall();
    int ir, mwp;
    run_instr(OP_LW, 2, 3, 0, "lw_stall", ir, mwp);
    n_cmp++;
    if (ir != 1) begin
      n_bad++;
      $display("FAIL lw_irwrite_pulses: got %0d expected 1", ir);
    end
  endtask

  task automatic test_back_to_back();
    int ir, mwp;
    run_instr(OP_SW, 0, 0, 0, "sw", ir, mwp);
    n_cmp++;
    if (mwp != 1) begin
      n_bad++;
      $display("FAIL sw_memwrite_pulses: got %0d expected 1", mwp);
    end
    run_instr(OP_BEQ, 0, 0, 0, "beq", ir, mwp);
    run_instr(OP_J, 0, 0, 0, "j", ir, mwp);
  endtask

  task automatic test_illegal();
    int a, b;
    run_instr(6'b111111, 0, 0, 0, "illegal", a, b);
    expect_fetch_idle("illegal_return");
  endtask

  task automatic test_reset_in_memwrite();
    int a, b;
    run_instr(OP_SW, 0, 5, 4, "sw_pre_reset", a, b);
    reset = 1'b1; bus.mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.MemWrite !== 1'b0 || dut_out() !== ctl_t'(0)) begin
      n_bad++;
      $display("FAIL reset_in_memwrite: got MemWrite %b outputs %h expected 0",
               bus.MemWrite, dut_out());
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_fetch_idle("after_memwrite_reset");
  endtask

  task automatic test_random();
    logic [5:0] ops [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    logic [5:0] op;
    int a, b;
    for (int k = 0; k < 40; k++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 0, "random", a, b);
    end
    expect_fetch_idle("random_end");
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = '0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_back_to_back();
    test_illegal();
    test_reset_in_memwrite();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control state machine for the multicycle MIPS datapath. It decodes the instruction opcode and sequences fetch, decode, execute, memory and write-back over several cycles. It drives every datapath mux and enable, and supplies `ALUOp` to the ALU control unit, which then resolves the R-type function field. Memory accesses use a `mem_ready` handshake, so the FSM stalls for slow memory.

## Interface
- Parameters: none.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  6  instruction register bits [31:26]; valid from DECODE onward.
- `mem_ready`  in  1  memory completion; sampled only in FETCH, MEMREAD and MEMWRITE.
- `PCWrite`  out  1  unconditional PC load.
- `PCWriteCond`  out  1  PC load qualified by ALU zero (beq).
- `IorD`  out  1  memory address source: 0 = PC, 1 = ALUOut.
- `MemRead`  out  1  memory read request.
- `MemWrite`  out  1  memory write request.
- `IRWrite`  out  1  instruction register load.
- `MemtoReg`  out  1  register write data source: 0 = ALUOut, 1 = MDR.
- `RegDst`  out  1  destination register: 0 = rt, 1 = rd.
- `RegWrite`  out  1  register file write enable.
- `ALUSrcA`  out  1  ALU A operand: 0 = PC, 1 = register A.
- `ALUSrcB`  out  2  ALU B operand: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `ALUOp`  out  2  ALU control input: 00 = add, 01 = subtract, 10 = use funct field.
- `PCSource`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state`  out  4  current state encoding, for debug and verification.
- `illegal_op`  out  1  unsupported opcode detected.

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5.
  - EXECUTE = 6, ALUWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11.
  - Encodings 12–15 are unreachable; if entered, the next state is FETCH.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Transitions:
  - FETCH → DECODE when `mem_ready` = 1; otherwise stay in FETCH.
  - DECODE → MEMADR (lw, sw), EXECUTE (R-type), BRANCH (beq), JUMP (j), ADDIEX (addi).
  - DECODE → FETCH for any other opcode.
  - MEMADR → MEMREAD (lw) or MEMWRITE (sw). The decision uses `opcode`, which must be held by the IR.
  - MEMREAD → MEMWB when `mem_ready` = 1; otherwise stay.
  - MEMWRITE → FETCH when `mem_ready` = 1; otherwise stay.
  - EXECUTE → ALUWB. ADDIEX → ADDIWB.
  - MEMWB, ALUWB, BRANCH, JUMP and ADDIWB all → FETCH.
- Outputs are decoded from the current state only (Moore), except `PCWrite` and `IRWrite` in FETCH, which are gated by `mem_ready`. Any output not listed for a state is 0.
  - FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00, `IRWrite`=`PCWrite`=`mem_ready`.
  - DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00 (precomputes the branch target).
  - DECODE with an unsupported opcode additionally drives `illegal_op`=1.
  - MEMADR and ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00.
  - MEMREAD: `MemRead`=1, `IorD`=1.
  - MEMWRITE: `MemWrite`=1, `IorD`=1.
  - MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0.
  - EXECUTE: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10.
  - ALUWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0.
  - BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01.
  - JUMP: `PCWrite`=1, `PCSource`=10.
  - ADDIWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0.
- `MemRead` and `MemWrite` are never asserted together.
- `RegWrite` and `PCWrite` never assert in the same cycle.

## Timing
- Reset:
  - While `reset` is high at a rising edge, the state register loads FETCH.
  - In any cycle in which `reset` is high, all outputs are forced to 0, including `MemRead`, and `state` reads 0.
  - Reset asserted mid-instruction abandons that instruction; no partial write-back occurs after the reset edge.
- Cycle counts with zero memory wait, FETCH to the return to FETCH:
  - R-type 4, addi 4, lw 5, sw 4, beq 3, j 3, illegal 2.
- Each cycle with `mem_ready` = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
  - During a stall, all outputs stay constant and `IRWrite`/`PCWrite` stay at 0.
- `mem_ready` asserted in any other state is ignored.
- `mem_ready` is not required to deassert between accesses. A held-high `mem_ready` gives the minimum cycle counts.
- `opcode` is sampled in DECODE and in MEMADR. It may change freely during FETCH.
- `illegal_op` is high for exactly the one DECODE cycle.

## Test plan
- Reset hold: assert `reset` for 3 cycles from an arbitrary state, with `opcode`=000000 and `mem_ready`=1 → every output is 0 during reset, and `state`=0 with `MemRead`=1 on the first cycle after release.
- R-type with `mem_ready` tied to 1 → state sequence 0, 1, 6, 7, 0. `ALUOp`=10 in state 6. `RegWrite`=1 and `RegDst`=1 only in state 7.
- lw with `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEMREAD → sequence 0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 0 (10 cycles). `IRWrite` pulses exactly once; `MemtoReg`=1 and `RegWrite`=1 in state 4.
- sw, then beq, then j, back to back, with `mem_ready`=1 → sequences 0, 1, 2, 5 / 0, 1, 8 / 0, 1, 9.
  - `MemWrite` is asserted for exactly one cycle.
  - In state 8: `PCWriteCond`=1, `PCSource`=01, `ALUOp`=01.
  - In state 9: `PCWrite`=1, `PCSource`=10.
- Illegal opcode 111111 → sequence 0, 1, 0. `illegal_op`=1 only in the DECODE cycle. No `RegWrite`, `MemWrite` or `PCWriteCond` is asserted.
- `reset` asserted in MEMWRITE while `mem_ready`=0, then released → `MemWrite` drops to 0 in the reset cycle, and the next state is FETCH rather than MEMWRITE.
